// File: rtl/axi_lite_pkg.sv
// AXI4-Lite response encodings shared by the read-data, read-address and write channel blocks.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // SLVERR and DECERR both carry bit 1 set; OKAY and EXOKAY do not.
  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/rdata_fifo_mem.sv
// Storage array for the read-data buffer: one write port, one asynchronous read port, no reset.
module rdata_fifo_mem #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                     ACLK,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge ACLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axi_lite_rdata_buffer.sv
// AXI4-Lite R-channel buffer: DEPTH-entry FIFO of {RRESP, RDATA} with registered handshake
// flags, an exported fill level and a saturating error-response counter.
module axi_lite_rdata_buffer
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic                       s_RVALID,
  output logic                       s_RREADY,
  input  logic [DATA_WIDTH-1:0]      s_RDATA,
  input  logic [1:0]                 s_RRESP,
  output logic                       m_RVALID,
  input  logic                       m_RREADY,
  output logic [DATA_WIDTH-1:0]      m_RDATA,
  output logic [1:0]                 m_RRESP,
  output logic [$clog2(DEPTH):0]     level,
  output logic [ERR_CNT_WIDTH-1:0]   err_count,
  input  logic                       err_clear
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = DATA_WIDTH + 2;
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [LVL_W-1:0]         level_q;
  logic [LVL_W-1:0]         level_next;
  logic                     s_ready_q;
  logic                     m_valid_q;
  logic [ERR_CNT_WIDTH-1:0] err_q;
  logic                     push;
  logic                     pop;
  logic [ENTRY_W-1:0]       rd_entry;

  assign push = s_RVALID && s_ready_q;
  assign pop  = m_valid_q && m_RREADY;

  rdata_fifo_mem #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .ACLK    (ACLK),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data ({s_RRESP, s_RDATA}),
    .rd_addr (rd_ptr),
    .rd_data (rd_entry)
  );

  always_comb begin
    level_next = level_q;
    if (push && !pop) begin
      level_next = level_q + 1'b1;
    end else if (!push && pop) begin
      level_next = level_q - 1'b1;
    end
  end

  // Flags are registered from the next level so neither handshake input reaches the opposite side.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      err_q     <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level_q   <= level_next;
      s_ready_q <= (level_next != FULL_LEVEL);
      m_valid_q <= (level_next != '0);
      if (err_clear) begin
        err_q <= '0;
      end else if (push && resp_is_error(s_RRESP) && (err_q != '1)) begin
        err_q <= err_q + 1'b1;
      end
    end
  end

  assign s_RREADY  = s_ready_q;
  assign m_RVALID  = m_valid_q;
  assign m_RDATA   = m_valid_q ? rd_entry[DATA_WIDTH-1:0] : '0;
  assign m_RRESP   = m_valid_q ? rd_entry[ENTRY_W-1 -: 2] : '0;
  assign level     = level_q;
  assign err_count = err_q;

endmodule

// File: doc/axi_lite_rdata_buffer.md
# axi_lite_rdata_buffer

Parametrised AXI4-Lite read-data (R) channel buffer placed between a slave's R-channel output and the master's R-channel input. Replaces the unbuffered read-data master/slave pair with a DEPTH-entry FIFO that carries RDATA and RRESP together. It provides full VALID/READY back-pressure on both sides, exports the fill level, and keeps a saturating count of error responses.

## Interface
- DATA_WIDTH, 32, RDATA width in bits; must be 32 or 64.
- DEPTH, 4, number of buffered beats; must be a power of two and at least 2.
- ERR_CNT_WIDTH, 8, width of the error counter.

- ACLK  in  1  clock; all logic is on the rising edge.
- ARESET  in  1  reset; synchronous, active-high.
- s_RVALID  in  1  the slave offers a beat.
- s_RREADY  out  1  the buffer can accept a beat.
- s_RDATA  in  DATA_WIDTH  read data from the slave.
- s_RRESP  in  2  response from the slave.
- m_RVALID  out  1  the buffer holds a beat for the master.
- m_RREADY  in  1  the master accepts the beat.
- m_RDATA  out  DATA_WIDTH  head-of-buffer data; zero when m_RVALID=0.
- m_RRESP  out  2  head-of-buffer response; zero when m_RVALID=0.
- level  out  $clog2(DEPTH)+1  number of occupied entries.
- err_count  out  ERR_CNT_WIDTH  count of accepted beats with RRESP of SLVERR or DECERR.
- err_clear  in  1  clears err_count.

## Operation
- Push: occurs when s_RVALID && s_RREADY. The {s_RRESP, s_RDATA} pair is written at the write pointer, and the write pointer advances modulo DEPTH.
- Pop: occurs when m_RVALID && m_RREADY. The read pointer advances modulo DEPTH.
- Flag derivation: s_RREADY = (level != DEPTH) and m_RVALID = (level != 0). Both come from registers only. There is no combinational path from m_RREADY to s_RREADY or from s_RVALID to m_RVALID.
- Level update:
  - push only: level + 1
  - pop only: level − 1
  - both push and pop: unchanged
  - neither: unchanged
- Full: s_RREADY=0 and no push occurs. A pop in the same cycle frees one entry, so s_RREADY rises in the next cycle.
- Empty: m_RVALID=0 and m_RDATA/m_RRESP are driven to 0. There is no bypass path; a beat is never visible in the cycle it is pushed.
- Pointer wrap: pointers are $clog2(DEPTH) bits wide and wrap naturally. Full and empty are distinguished by level, not by pointer comparison.
- Stability: once m_RVALID=1, m_RDATA/m_RRESP hold their value until the pop, as AXI requires.
- err_count:
  - increments on each push with s_RRESP[1]=1 (2'b10 or 2'b11)
  - saturates at all-ones
  - err_clear has priority: if err_clear and an error push occur in the same cycle, the result is 0
  - OKAY and EXOKAY responses do not count
- Reset: while ARESET=1, all of the following hold; storage contents are not reset:
  - level=0 and both pointers are 0
  - err_count=0
  - m_RVALID=0
  - s_RREADY=0
- Reset mid-transfer: any beats held in the buffer are discarded. In the first cycle after ARESET deasserts, s_RREADY=1 and m_RVALID=0.

## Timing
- Latency: a beat pushed at edge N appears with m_RVALID=1 during cycle N+1.
- Throughput: one beat per cycle with simultaneous push and pop at any level from 1 to DEPTH−1.
- level and err_count are registered and reflect edge N in cycle N+1.
- s_RREADY updates one cycle after a pop frees space. A DEPTH=2 buffer therefore sustains full rate only while the master never stalls.

## Structure
- Shared package axi_lite_pkg holds the RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10 and RESP_DECERR=2'b11 constants. The read-address and write channels will reuse them.
- Sub-module rdata_fifo_mem is the DEPTH × (DATA_WIDTH+2) storage array:
  - one write port and one asynchronous read port
  - no reset
- The top level holds pointers, level, flags, output zeroing and the error counter.

## Test plan
- Reset, then push 4 beats (0xA0..0xA3, OKAY) with m_RREADY=0, DEPTH=4 → level=4, s_RREADY=0. A fifth beat 0xA4 held on s_RVALID is not accepted.
- Raise m_RREADY from the full state → pops occur in order 0xA0..0xA3. s_RREADY=1 one cycle after the first pop, then 0xA4 is accepted and emerges last.
- Continuous streaming of 0x100..0x10F with both VALID and READY held high → one beat per cycle, order preserved, level stays constant at 1.
- Push RRESP values 10, 11, 00, 01, 10 → err_count=3. Assert err_clear in the same cycle as an SLVERR push → err_count=0.
- With ERR_CNT_WIDTH=2, push 5 DECERR beats → err_count saturates at 3.
- Assert ARESET with level=3 → the next cycle shows level=0, m_RVALID=0, m_RDATA=0, s_RREADY=0. After ARESET deasserts, s_RREADY=1.
